sw_debounce: RTL

//   Upstream conditioning stage for the switch display block: takes raw board DIP switches,

---
 rtl/sw_debounce.sv | 100 ++++++++++
 1 files changed

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus whole-vector debouncer for board DIP switches.
// Optional accepted-change counter on chg_cnt when SW_CHG_CNT_EN is defined.
module sw_debounce #(
    parameter int WIDTH     = 4,
    parameter int DB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] switch,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_prev,
    output logic             sw_chg,
    output logic [7:0]       chg_cnt
);

    localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_e;

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             chg_q, chg_d;
    state_e           state;

    // State is implied by whether the candidate differs from the accepted value.
    assign state = (cand_q == stable_q) ? IDLE : PENDING;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            stable_q <= '0;
            prev_q   <= '0;
            cnt_q    <= '0;
            chg_q    <= 1'b0;
        end else begin
            sync1_q  <= switch;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            chg_q    <= chg_d;
        end
    end

    // Any movement of the synchronised input restarts the hold window.
    always_comb begin
        cand_d   = cand_q;
        stable_d = stable_q;
        prev_d   = prev_q;
        cnt_d    = cnt_q;
        chg_d    = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (state == IDLE) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            prev_d   = stable_q;
            stable_d = cand_q;
            cnt_d    = '0;
            chg_d    = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    assign sw_stable = stable_q;
    assign sw_prev   = prev_q;
    assign sw_chg    = chg_q;

`ifdef SW_CHG_CNT_EN
    logic [7:0] chg_cnt_q, chg_cnt_d;

    always_comb begin
        chg_cnt_d = chg_cnt_q;
        if (chg_q) chg_cnt_d = chg_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) chg_cnt_q <= 8'd0;
        else       chg_cnt_q <= chg_cnt_d;
    end

    assign chg_cnt = chg_cnt_q;
`else
    assign chg_cnt = 8'd0;
`endif

endmodule
